// File: rtl/riscv_pkg.sv
// Shared fetch-side types: data width, fetch FSM states and the queued {pc,inst} entry.
package riscv_pkg;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fifo.sv
// Small power-of-two instruction queue; flush empties it and overrides push/pop.
module inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        do_pop;

  assign do_pop = pop && (count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem[wr_ptr] <= push_data;
  end

  // Empty queue presents zeros so stale storage never leaks to the decoder.
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;
endmodule

// File: rtl/ifetch_buffer.sv
// Instruction fetch: one outstanding memory read at a time, results queued for decode.
module ifetch_buffer
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in_data,
  output logic            pc_stall,
  input  logic            redirect,
  output logic            mem_req_valid,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_req_ready,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e    state, state_n;
  logic            discard, discard_n;
  logic [XLEN-1:0] addr_q, addr_n;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  logic            free;
  logic            push;
  fetch_entry_t    push_entry, head_entry;

  // An in-flight fetch already owns a slot, so it counts against occupancy.
  assign occ  = {1'b0, count} + {{CW{1'b0}}, (state != IDLE)};
  assign free = occ < (CW+1)'(DEPTH);

  always_comb begin
    state_n       = state;
    discard_n     = discard;
    addr_n        = addr_q;
    pc_stall      = 1'b1;
    mem_req_valid = 1'b0;
    push          = 1'b0;
    case (state)
      IDLE: begin
        if (free && !redirect) begin
          addr_n   = pc_in_data;
          pc_stall = 1'b0;
          state_n  = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (redirect)      discard_n = 1'b1;
        if (mem_req_ready) state_n   = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid) begin
          push      = !discard && !redirect;
          discard_n = 1'b0;
          state_n   = IDLE;
        end else if (redirect) begin
          discard_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (rst) pc_stall = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      discard <= 1'b0;
      addr_q  <= '0;
    end else begin
      state   <= state_n;
      discard <= discard_n;
      addr_q  <= addr_n;
    end
  end

  assign mem_req_addr = addr_q;
  assign push_entry   = '{pc: addr_q, inst: mem_rsp_data};

  inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (inst_valid && inst_ready),
    .head_data (head_entry),
    .count     (count)
  );

  assign inst_valid = (count != '0);
  assign inst_data  = head_entry.inst;
  assign inst_pc    = head_entry.pc;
endmodule

// File: tb/tb_ifetch_buffer.sv
// Randomised + directed bench for ifetch_buffer against a queue-based fetch model.
module tb_ifetch_buffer;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst, redirect, mem_req_ready, mem_rsp_valid, inst_ready;
  logic [31:0] pc_in_data, mem_rsp_data;
  logic        pc_stall, mem_req_valid, inst_valid;
  logic [31:0] mem_req_addr, inst_data, inst_pc;

  always #5 clk = ~clk;

  ifetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_in_data    (pc_in_data),
    .pc_stall      (pc_stall),
    .redirect      (redirect),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .inst_valid    (inst_valid),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .inst_ready    (inst_ready)
  );

  int n_tests = 0, n_fail = 0;

  // stimulus knobs
  logic        s_rst = 1'b1, s_redirect = 1'b0, s_inst_ready = 1'b0, s_req_ready = 1'b1;
  logic [31:0] s_pc = '0;
  int          s_rsp_delay = 0;
  logic        s_ovr_en = 1'b0;
  logic [31:0] s_ovr_data = '0;

  // model: queue of {pc,inst}, plus one abstract in-flight fetch
  logic [63:0] mq[$];
  logic        m_inflight = 0, m_pend = 0, m_killed = 0, chk_en = 0;
  logic [31:0] m_fpc = '0;
  int          cyc = 0, rsp_at = -1, dut_acc = 0;
  logic [31:0] rsp_data = '0;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00000013;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h expected %h", n, cyc, act, exp);
    end
  endtask

  task automatic step();
    logic e_stall;
    @(negedge clk);
    rst           = s_rst;
    redirect      = s_redirect;
    pc_in_data    = s_pc;
    inst_ready    = s_inst_ready;
    mem_req_ready = s_req_ready;
    mem_rsp_valid = (rsp_at == cyc);
    mem_rsp_data  = mem_rsp_valid ? rsp_data : $urandom;
    #1;
    e_stall = s_rst || s_redirect || m_inflight || (mq.size() >= DEPTH);
    if (chk_en) begin
      chk("pc_stall", 32'(pc_stall), 32'(e_stall));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_inflight && m_pend));
      if (m_inflight && m_pend) chk("mem_req_addr", mem_req_addr, m_fpc);
      chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("inst_pc", inst_pc, mq[0][63:32]);
        chk("inst_data", inst_data, mq[0][31:0]);
      end
    end
    if (!s_rst && mem_req_valid && mem_req_ready) dut_acc++;
    if (s_rst) begin
      mq.delete();
      m_inflight = 0; m_pend = 0; m_killed = 0; chk_en = 1;
    end else begin
      if (mq.size() != 0 && s_inst_ready && !s_redirect) void'(mq.pop_front());
      if (s_redirect) begin
        mq.delete();
        if (m_inflight) m_killed = 1;
      end
      if (m_inflight && m_pend) begin
        if (s_req_ready) begin
          m_pend   = 0;
          rsp_at   = cyc + ((s_rsp_delay == 0) ? int'($urandom_range(1, 2)) : s_rsp_delay);
          rsp_data = s_ovr_en ? s_ovr_data : memfn(m_fpc);
        end
      end else if (m_inflight) begin
        if (mem_rsp_valid) begin
          if (!m_killed && !s_redirect) mq.push_back({m_fpc, mem_rsp_data});
          m_inflight = 0;
        end
      end else if (!e_stall) begin
        m_inflight = 1; m_pend = 1; m_fpc = s_pc; m_killed = 0;
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    s_rst = 1'b1; s_redirect = 1'b0;
    step(); step();
    s_rst = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_req_addr"},  mem_req_addr, 32'd0);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_inst_pc"},   inst_pc, 32'd0);
    chk({tag, "_pc_stall"},  32'(pc_stall), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  a0, first_pc;
    bit  seen_bad, seen, got;

    // reset values, minimum latency, then push+pop at count=1
    s_req_ready = 1; s_inst_ready = 0; s_rsp_delay = 1;
    s_ovr_en = 1; s_ovr_data = 32'h00000013; s_pc = 32'h00010000;
    s_rst = 1; step(); step();
    chk_reset_outputs("rst");
    s_rst = 0;
    step(); chk("lat_c0_stall", 32'(pc_stall), 32'd0);
    step(); chk("lat_c1_req", 32'(mem_req_valid), 32'd1);
            chk("lat_c1_addr", mem_req_addr, 32'h00010000);
    step(); chk("lat_c2_inv", 32'(inst_valid), 32'd0);
    s_ovr_en = 0; s_pc = 32'h00020000;
    step(); chk("lat_c3_inv", 32'(inst_valid), 32'd1);
            chk("lat_c3_pc", inst_pc, 32'h00010000);
            chk("lat_c3_data", inst_data, 32'h00000013);
    step();
    s_inst_ready = 1;
    step(); chk("pp_head_before", inst_pc, 32'h00010000);
    s_inst_ready = 0;
    step(); chk("pp_inv", 32'(inst_valid), 32'd1);
            chk("pp_head_after", inst_pc, 32'h00020000);
            chk("pp_count1_free", 32'(pc_stall), 32'd0);

    // queue fill with decoder stalled
    do_reset();
    s_inst_ready = 0; s_req_ready = 1; s_rsp_delay = 0;
    a0 = dut_acc;
    for (int i = 0; i < 20; i++) begin
      s_pc = 32'h00030000 + 32'(4*i);
      step();
    end
    chk("fill_accepts", 32'(dut_acc - a0), 32'd2);
    chk("fill_stall", 32'(pc_stall), 32'd1);
    chk("fill_no_req", 32'(mem_req_valid), 32'd0);
    s_inst_ready = 1; step(); s_inst_ready = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (mem_req_valid) seen = 1;
    end
    chk("fill_req_after_pop", 32'(seen), 32'd1);

    // memory back-pressure
    do_reset();
    s_inst_ready = 1; s_req_ready = 0; s_pc = 32'h00040000;
    step();
    s_pc = 32'h0004FFF0;
    a0 = dut_acc;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_valid", 32'(mem_req_valid), 32'd1);
      chk("bp_addr", mem_req_addr, 32'h00040000);
    end
    s_req_ready = 1;
    step(); step();
    chk("bp_one_accept", 32'(dut_acc - a0), 32'd1);

    // redirect while waiting; late response must vanish
    do_reset();
    s_inst_ready = 1; s_req_ready = 1; s_pc = 32'h00050000;
    s_rsp_delay = 3; s_ovr_en = 1; s_ovr_data = 32'hDEADBEEF;
    step(); step();
    s_ovr_en = 0; s_rsp_delay = 1;
    s_redirect = 1; s_pc = 32'h00010100;
    step();
    s_redirect = 0;
    seen_bad = 0; got = 0; first_pc = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (inst_valid && inst_data == 32'hDEADBEEF) seen_bad = 1;
      if (inst_valid) begin got = 1; first_pc = int'(inst_pc); end
    end
    chk("redir_dropped", 32'(seen_bad), 32'd0);
    chk("redir_got_inst", 32'(got), 32'd1);
    chk("redir_target_pc", 32'(first_pc), 32'h00010100);

    // reset in the middle of REQ
    do_reset();
    s_req_ready = 0; s_pc = 32'h00060000;
    step(); step();
    chk("mreq_valid", 32'(mem_req_valid), 32'd1);
    s_rst = 1; step(); step();
    chk_reset_outputs("mreq");
    s_rst = 0;

    // reset during WAIT; response lands afterwards and must be ignored
    s_req_ready = 1; s_rsp_delay = 2; s_inst_ready = 1; s_pc = 32'h00070000;
    step(); step();
    s_rst = 1; step(); s_rst = 0;
    step(); chk("stale_c0", 32'(inst_valid), 32'd0);
    step(); chk("stale_c1", 32'(inst_valid), 32'd0);

    // random traffic
    s_rsp_delay = 0; s_ovr_en = 0;
    for (int i = 0; i < 3000; i++) begin
      s_rst        = ($urandom_range(0, 199) == 0);
      s_redirect   = ($urandom_range(0, 9) == 0);
      s_pc         = $urandom & 32'hFFFF_FFFC;
      s_inst_ready = ($urandom_range(0, 1) == 1);
      s_req_ready  = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
